// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI endpoint: answers link TX CMDs, holds the PHY register file, injects RX CMDs and RX packets.
// Optional ULPI_PHY_THROTTLE_EN: LFSR-driven nxt wait cycles during TRANSMIT data.
module ulpi_phy_emu #(
  parameter int         REG_COUNT    = 16,
  parameter logic [7:0] FUNC_CTRL_RV = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe,
  output logic       ulpi_dir,
  output logic       ulpi_nxt,
  input  logic       ulpi_stp,
  input  logic [7:0] rxcmd_data,
  input  logic       rxcmd_valid,
  output logic       rxcmd_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_last,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic [3:0] tx_pid,
  output logic       tx_sop,
  output logic       tx_eop,
  input  logic [5:0] reg_dbg_addr,
  output logic [7:0] reg_dbg_data
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD_ACK, S_TX_DATA, S_REGW_DATA, S_REGW_STP, S_REGR_TURN, S_REGR_DATA,
    S_RXC_TURN, S_RXC_DATA, S_RX_TURN, S_RX_DATA, S_TURNBACK
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [3:0] pid_q, pid_d;
  logic [7:0] last_rxcmd_q, last_rxcmd_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       tx_sop_q, tx_sop_d;
  logic       tx_eop_q, tx_eop_d;
  logic       reg_we;
  logic       tx_nxt;
  logic [7:0] reg_rd_data;
  logic [7:0] regs_q [64];

`ifdef ULPI_PHY_THROTTLE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= 16'hACE1;
    else       lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign tx_nxt = lfsr_q[0];
`else
  assign tx_nxt = 1'b1;
`endif

  // Only the lowest REG_COUNT entries are ever written; the rest stay at zero and read back as zero.
  assign reg_rd_data  = (int'(addr_q) < REG_COUNT) ? regs_q[addr_q] : 8'h00;
  assign reg_dbg_data = (int'(reg_dbg_addr) < REG_COUNT) ? regs_q[reg_dbg_addr] : 8'h00;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign tx_pid   = pid_q;
  assign tx_sop   = tx_sop_q;
  assign tx_eop   = tx_eop_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    pid_d         = pid_q;
    last_rxcmd_d  = last_rxcmd_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = 1'b0;
    tx_sop_d      = 1'b0;
    tx_eop_d      = 1'b0;
    reg_we        = 1'b0;
    ulpi_dir      = 1'b0;
    ulpi_nxt      = 1'b0;
    ulpi_data_oe  = 1'b0;
    ulpi_data_out = 8'h00;
    rxcmd_ready   = 1'b0;
    rx_ready      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // PHY-originated traffic wins; the link backs off when it sees dir rise.
        if (rx_valid)                                  state_d = S_RX_TURN;
        else if (rxcmd_valid)                          state_d = S_RXC_TURN;
        else if (ulpi_data_in[7:6] != 2'b00 && !ulpi_stp) state_d = S_CMD_ACK;
      end
      S_CMD_ACK: begin
        ulpi_nxt = 1'b1;
        addr_d   = ulpi_data_in[5:0];
        case (ulpi_data_in[7:6])
          2'b01:   begin state_d = S_TX_DATA; tx_sop_d = 1'b1; pid_d = ulpi_data_in[3:0]; end
          2'b10:   state_d = S_REGW_DATA;
          2'b11:   state_d = S_REGR_TURN;
          default: state_d = S_IDLE;
        endcase
      end
      S_TX_DATA: begin
        ulpi_nxt = tx_nxt;
        if (ulpi_stp) begin
          tx_eop_d = 1'b1;
          state_d  = S_IDLE;
        end else if (tx_nxt) begin
          tx_data_d  = ulpi_data_in;
          tx_valid_d = 1'b1;
        end
      end
      S_REGW_DATA: begin
        ulpi_nxt = 1'b1;
        wdata_d  = ulpi_data_in;
        state_d  = S_REGW_STP;
      end
      S_REGW_STP: begin
        if (ulpi_stp) begin
          reg_we  = (int'(addr_q) < REG_COUNT) && (addr_q != 6'h2F);
          state_d = S_IDLE;
        end
      end
      S_REGR_TURN: begin
        ulpi_dir = 1'b1;
        state_d  = S_REGR_DATA;
      end
      S_REGR_DATA: begin
        ulpi_dir      = 1'b1;
        ulpi_data_oe  = 1'b1;
        ulpi_data_out = reg_rd_data;
        state_d       = S_TURNBACK;
      end
      S_RXC_TURN: begin
        ulpi_dir = 1'b1;
        state_d  = S_RXC_DATA;
      end
      S_RXC_DATA: begin
        ulpi_dir      = 1'b1;
        ulpi_data_oe  = 1'b1;
        ulpi_data_out = rxcmd_data;
        rxcmd_ready   = 1'b1;
        last_rxcmd_d  = rxcmd_data;
        state_d       = S_TURNBACK;
      end
      S_RX_TURN: begin
        ulpi_dir = 1'b1;
        ulpi_nxt = 1'b1;
        state_d  = S_RX_DATA;
      end
      S_RX_DATA: begin
        ulpi_dir     = 1'b1;
        ulpi_data_oe = 1'b1;
        if (rx_valid) begin
          ulpi_nxt      = 1'b1;
          ulpi_data_out = rx_data;
          rx_ready      = 1'b1;
          if (rx_last) state_d = S_TURNBACK;
        end else begin
          ulpi_data_out = last_rxcmd_q;
        end
      end
      S_TURNBACK: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= 6'h00;
      wdata_q      <= 8'h00;
      pid_q        <= 4'h0;
      last_rxcmd_q <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pid_q        <= pid_d;
      last_rxcmd_q <= last_rxcmd_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_sop_q     <= tx_sop_d;
      tx_eop_q     <= tx_eop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) regs_q[i] <= (i == 4) ? FUNC_CTRL_RV : 8'h00;
    end else if (reg_we) begin
      regs_q[addr_q] <= wdata_q;
    end
  end

endmodule
